// File: rtl/bti_pkg.sv
// Shared BTI definitions: command encodings, arbitration modes, index helpers.
// No logic; constants and constant-foldable functions only.
// Used by the arbiter/mux top and its testbench.
package bti_pkg;

  localparam logic BTI_CMD_RD = 1'b0;
  localparam logic BTI_CMD_WR = 1'b1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Low bit of lane idx in a vector packed from lanes of width w
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  // Width of a host index; a single bit even for the two-host case
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // (base + inc) mod n, for rotating priority
  function automatic int wrap_add(input int base, input int inc, input int n);
    return (base + inc) % n;
  endfunction

endpackage

// File: rtl/bti_arb_mux_if.sv
// Host-side and guest-side BTI request/response bundle for the arbiter/mux.
// No latency; wires only.
// Flow control is plain valid/ready on every request and response channel.
interface bti_arb_mux_if #(
  parameter int BTI_AW   = 32,
  parameter int BTI_DW   = 32,
  parameter int HOST_NUM = 2
);

  logic [HOST_NUM-1:0]            host_req_vld;
  logic [HOST_NUM-1:0]            host_req_rdy;
  logic [HOST_NUM*BTI_AW-1:0]     host_req_addr;
  logic [HOST_NUM-1:0]            host_req_cmd;
  logic [HOST_NUM*BTI_DW-1:0]     host_req_wdata;
  logic [HOST_NUM*BTI_DW/8-1:0]   host_req_strb;
  logic [HOST_NUM-1:0]            host_rsp_vld;
  logic [HOST_NUM-1:0]            host_rsp_rdy;
  logic [BTI_DW-1:0]              host_rsp_data;
  logic                           host_rsp_err;

  logic                           gst_req_vld;
  logic                           gst_req_rdy;
  logic [BTI_AW-1:0]              gst_req_addr;
  logic                           gst_req_cmd;
  logic [BTI_DW-1:0]              gst_req_wdata;
  logic [BTI_DW/8-1:0]            gst_req_strb;
  logic                           gst_rsp_vld;
  logic                           gst_rsp_rdy;
  logic [BTI_DW-1:0]              gst_rsp_data;
  logic                           gst_rsp_err;

  logic                           orphan_rsp;

  // Arbiter/mux view
  modport slave (
    input  host_req_vld, host_req_addr, host_req_cmd, host_req_wdata, host_req_strb,
    input  host_rsp_rdy, gst_req_rdy, gst_rsp_vld, gst_rsp_data, gst_rsp_err,
    output host_req_rdy, host_rsp_vld, host_rsp_data, host_rsp_err,
    output gst_req_vld, gst_req_addr, gst_req_cmd, gst_req_wdata, gst_req_strb,
    output gst_rsp_rdy, orphan_rsp
  );

  // Environment view: drives the hosts and the guest
  modport master (
    output host_req_vld, host_req_addr, host_req_cmd, host_req_wdata, host_req_strb,
    output host_rsp_rdy, gst_req_rdy, gst_rsp_vld, gst_rsp_data, gst_rsp_err,
    input  host_req_rdy, host_rsp_vld, host_rsp_data, host_rsp_err,
    input  gst_req_vld, gst_req_addr, gst_req_cmd, gst_req_wdata, gst_req_strb,
    input  gst_rsp_rdy, orphan_rsp
  );

endinterface

// File: rtl/bti_id_fifo.sv
// Outstanding-ID FIFO: records the issuing host of each accepted request.
// Head is combinational from storage; push/pop take effect on the next edge.
// Push is dropped when full and pop when empty; callers gate on full/empty.
module bti_id_fifo #(
  parameter int DW    = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                push_dat,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DW-1:0]                head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count guards every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bti_arb_mux.sv
// N-host to one-guest BTI arbiter/mux with in-order response steering by host ID.
// Zero added latency: request and response paths are combinational.
// A stalled grant is locked until accepted; requests stop while OST_DEPTH IDs are outstanding.
module bti_arb_mux
  import bti_pkg::*;
#(
  parameter int BTI_AW    = 32,
  parameter int BTI_DW    = 32,
  parameter int HOST_NUM  = 2,
  parameter int OST_DEPTH = 4,
  parameter int ARB_MODE  = 0
) (
  input  logic         clk,
  input  logic         rst,
  bti_arb_mux_if.slave bus
);

  localparam int IDW = id_width(HOST_NUM);
  localparam int CW  = $clog2(OST_DEPTH + 1);
  localparam int SW  = BTI_DW / 8;

  logic [IDW-1:0] rr_ptr;
  logic           lock;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] arb_idx;
  logic [IDW-1:0] cand;
  logic           arb_found;
  logic [IDW-1:0] gnt;
  logic           grant_vld;
  logic           accept;
  logic           pop;
  logic           full;
  logic           empty;
  logic [CW-1:0]  ost_count;
  logic [IDW-1:0] head;
  logic           orphan_q;

  // Choose among requesting hosts: lowest index, or first at/after rr_ptr
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int k = HOST_NUM - 1; k >= 0; k--) begin
        if (bus.host_req_vld[k]) begin
          arb_found = 1'b1;
          arb_idx   = IDW'(k);
        end
      end
    end else begin
      for (int k = 0; k < HOST_NUM; k++) begin
        cand = IDW'(wrap_add(int'(rr_ptr), k, HOST_NUM));
        if (!arb_found && bus.host_req_vld[cand]) begin
          arb_found = 1'b1;
          arb_idx   = cand;
        end
      end
    end
  end

  assign gnt       = lock ? lock_id : arb_idx;
  assign grant_vld = !rst && !full && (lock || arb_found);
  assign accept    = bus.gst_req_vld & bus.gst_req_rdy;

  // Steer the granted host onto the guest and return ready to that host only
  always_comb begin
    bus.gst_req_vld   = grant_vld;
    bus.gst_req_addr  = '0;
    bus.gst_req_cmd   = BTI_CMD_RD;
    bus.gst_req_wdata = '0;
    bus.gst_req_strb  = '0;
    bus.host_req_rdy  = '0;
    for (int k = 0; k < HOST_NUM; k++) begin
      if (gnt == IDW'(k)) begin
        bus.gst_req_addr    = bus.host_req_addr[slice_lo(k, BTI_AW) +: BTI_AW];
        bus.gst_req_cmd     = bus.host_req_cmd[k];
        bus.gst_req_wdata   = bus.host_req_wdata[slice_lo(k, BTI_DW) +: BTI_DW];
        bus.gst_req_strb    = bus.host_req_strb[slice_lo(k, SW) +: SW];
        bus.host_req_rdy[k] = grant_vld & bus.gst_req_rdy;
      end
    end
  end

  // Route the guest response to the oldest outstanding host; discard it when none is outstanding
  always_comb begin
    bus.host_rsp_vld = '0;
    bus.gst_rsp_rdy  = 1'b0;
    if (!rst) begin
      if (ost_count == '0) begin
        bus.gst_rsp_rdy = 1'b1;
      end else begin
        for (int k = 0; k < HOST_NUM; k++) begin
          if (head == IDW'(k)) begin
            bus.host_rsp_vld[k] = bus.gst_rsp_vld;
            bus.gst_rsp_rdy     = bus.host_rsp_rdy[k];
          end
        end
      end
    end
  end

  assign bus.host_rsp_data = bus.gst_rsp_data;
  assign bus.host_rsp_err  = bus.gst_rsp_err;
  assign pop               = bus.gst_rsp_vld & bus.gst_rsp_rdy & ~empty;
  assign bus.orphan_rsp    = orphan_q;

  // Lock a stalled grant until the guest accepts it; rotate priority past the accepted host
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      lock <= 1'b0;
      if (ARB_MODE == ARB_RR) begin
        rr_ptr <= IDW'(wrap_add(int'(gnt), 1, HOST_NUM));
      end
    end else if (grant_vld) begin
      lock    <= 1'b1;
      lock_id <= gnt;
    end
  end

  // Sticky flag for a guest response that had no outstanding request to answer
  always_ff @(posedge clk) begin
    if (rst) begin
      orphan_q <= 1'b0;
    end else if (empty && bus.gst_rsp_vld) begin
      orphan_q <= 1'b1;
    end
  end

  bti_id_fifo #(
    .DW    (IDW),
    .DEPTH (OST_DEPTH)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (gnt),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (ost_count),
    .head     (head)
  );

endmodule

// File: tb/tb_bti_arb_mux.sv
// Directed bench for bti_arb_mux: a two-host round-robin instance and a three-host fixed-priority one.
// Expected grants and responses are queued as stimulus is driven and consumed by negedge monitors.
// Guest-side backpressure, FIFO-full blocking, lock hold and orphan handling are exercised directly.
module tb_bti_arb_mux;
  import bti_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bti_arb_mux_if #(.BTI_AW(32), .BTI_DW(32), .HOST_NUM(2)) a_if ();
  bti_arb_mux_if #(.BTI_AW(32), .BTI_DW(32), .HOST_NUM(3)) b_if ();

  bti_arb_mux #(
    .BTI_AW(32), .BTI_DW(32), .HOST_NUM(2), .OST_DEPTH(4), .ARB_MODE(ARB_RR)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  bti_arb_mux #(
    .BTI_AW(32), .BTI_DW(32), .HOST_NUM(3), .OST_DEPTH(3), .ARB_MODE(ARB_FIXED)
  ) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  typedef struct {
    int          host;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          host;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  req_t qa_req[$];
  rsp_t qa_rsp[$];
  int   qb_req[$];
  int   qb_rsp[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host k of the two-host instance: host 0 reads, host 1 writes
  task automatic exp_a(input int h, input logic [31:0] addr);
    req_t e;
    e.host  = h;
    e.addr  = addr;
    e.cmd   = (h == 1) ? BTI_CMD_WR : BTI_CMD_RD;
    e.wdata = (h == 1) ? 32'h2222_2222 : 32'h1111_1111;
    qa_req.push_back(e);
  endtask

  task automatic exp_a_rsp(input int h, input logic [31:0] data, input logic err);
    rsp_t r;
    r.host = h;
    r.data = data;
    r.err  = err;
    qa_rsp.push_back(r);
  endtask

  // Request and response monitors for the round-robin instance
  always @(negedge clk) begin
    if (!rst && a_if.gst_req_vld && a_if.gst_req_rdy) begin
      if (qa_req.size() == 0) begin
        chk("a_unexpected_req", a_if.gst_req_vld, 1'b0);
      end else begin
        req_t e;
        e = qa_req.pop_front();
        chk("a_gnt", a_if.host_req_rdy, 64'(1) << e.host);
        chk("a_addr", a_if.gst_req_addr, e.addr);
        chk("a_cmd", a_if.gst_req_cmd, e.cmd);
        chk("a_wdata", a_if.gst_req_wdata, e.wdata);
      end
    end
    if (!rst && a_if.gst_rsp_vld && a_if.gst_rsp_rdy && a_if.host_rsp_vld != '0) begin
      if (qa_rsp.size() == 0) begin
        chk("a_unexpected_rsp", a_if.host_rsp_vld, 2'b00);
      end else begin
        rsp_t r;
        r = qa_rsp.pop_front();
        chk("a_rsp_host", a_if.host_rsp_vld, 64'(1) << r.host);
        chk("a_rsp_data", a_if.host_rsp_data, r.data);
        chk("a_rsp_err", a_if.host_rsp_err, r.err);
      end
    end
  end

  // Request and response monitors for the fixed-priority instance
  always @(negedge clk) begin
    if (!rst && b_if.gst_req_vld && b_if.gst_req_rdy) begin
      if (qb_req.size() == 0) begin
        chk("b_unexpected_req", b_if.gst_req_vld, 1'b0);
      end else begin
        int h;
        h = qb_req.pop_front();
        chk("b_gnt", b_if.host_req_rdy, 64'(1) << h);
        chk("b_addr", b_if.gst_req_addr, 64'(32'h100 * (h + 1)));
      end
    end
    if (!rst && b_if.gst_rsp_vld && b_if.gst_rsp_rdy && b_if.host_rsp_vld != '0) begin
      if (qb_rsp.size() == 0) begin
        chk("b_unexpected_rsp", b_if.host_rsp_vld, 3'b000);
      end else begin
        int h;
        h = qb_rsp.pop_front();
        chk("b_rsp_host", b_if.host_rsp_vld, 64'(1) << h);
        chk("b_rsp_data", b_if.host_rsp_data, b_if.gst_rsp_data);
      end
    end
  end

  initial begin
    rst                 = 1'b1;
    a_if.host_req_vld   = '0;
    a_if.host_req_addr  = {32'h20, 32'h10};
    a_if.host_req_cmd   = {BTI_CMD_WR, BTI_CMD_RD};
    a_if.host_req_wdata = {32'h2222_2222, 32'h1111_1111};
    a_if.host_req_strb  = {4'hf, 4'h3};
    a_if.host_rsp_rdy   = '0;
    a_if.gst_req_rdy    = 1'b0;
    a_if.gst_rsp_vld    = 1'b0;
    a_if.gst_rsp_data   = '0;
    a_if.gst_rsp_err    = 1'b0;
    b_if.host_req_vld   = '0;
    b_if.host_req_addr  = {32'h300, 32'h200, 32'h100};
    b_if.host_req_cmd   = '0;
    b_if.host_req_wdata = '0;
    b_if.host_req_strb  = '0;
    b_if.host_rsp_rdy   = 3'b111;
    b_if.gst_req_rdy    = 1'b1;
    b_if.gst_rsp_vld    = 1'b0;
    b_if.gst_rsp_data   = '0;
    b_if.gst_rsp_err    = 1'b0;
    tick();
    tick();

    // Everything asserted during reset: outputs must stay low
    a_if.host_req_vld = 2'b11;
    a_if.gst_req_rdy  = 1'b1;
    a_if.gst_rsp_vld  = 1'b1;
    a_if.host_rsp_rdy = 2'b11;
    #2;
    chk("rst_gst_req_vld", a_if.gst_req_vld, 1'b0);
    chk("rst_host_req_rdy", a_if.host_req_rdy, 2'b00);
    chk("rst_gst_rsp_rdy", a_if.gst_rsp_rdy, 1'b0);
    chk("rst_host_rsp_vld", a_if.host_rsp_vld, 2'b00);
    a_if.host_req_vld = 2'b00;
    a_if.gst_rsp_vld  = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_orphan", a_if.orphan_rsp, 1'b0);
    chk("rst_rr_ptr", u_rr.rr_ptr, 1'b0);
    chk("rst_count", u_rr.u_id_fifo.count, 3'd0);

    // Both hosts requesting with a ready guest: grants alternate 0,1,0,1 until 4 are outstanding
    a_if.host_req_vld = 2'b11;
    exp_a(0, 32'h10);
    exp_a(1, 32'h20);
    exp_a(0, 32'h10);
    exp_a(1, 32'h20);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("rr_ptr_after_accept", u_rr.rr_ptr, ((i % 2) == 0) ? 1 : 0);
    end
    chk("full_gst_req_vld", a_if.gst_req_vld, 1'b0);
    chk("full_host_req_rdy", a_if.host_req_rdy, 2'b00);
    chk("full_count", u_rr.u_id_fifo.count, 3'd4);

    // One response pops the oldest ID (host 0); the push stays blocked this cycle
    a_if.gst_rsp_vld  = 1'b1;
    a_if.gst_rsp_data = 32'hAAAA;
    exp_a_rsp(0, 32'hAAAA, 1'b0);
    #1;
    chk("pop_host_rsp_vld", a_if.host_rsp_vld, 2'b01);
    chk("pop_gst_rsp_rdy", a_if.gst_rsp_rdy, 1'b1);
    chk("pop_same_cycle_blocked", a_if.gst_req_vld, 1'b0);
    tick();
    a_if.gst_rsp_vld = 1'b0;
    exp_a(0, 32'h10);
    #1;
    chk("pop_next_cycle_vld", a_if.gst_req_vld, 1'b1);
    tick();
    a_if.host_req_vld = 2'b00;

    // In-order responses: outstanding IDs are 1,0,1,0
    a_if.gst_rsp_vld  = 1'b1;
    a_if.gst_rsp_data = 32'hBBBB;
    exp_a_rsp(1, 32'hBBBB, 1'b0);
    #1;
    chk("inorder_host1", a_if.host_rsp_vld, 2'b10);
    tick();
    a_if.gst_rsp_data = 32'hCCCC;
    a_if.host_rsp_rdy = 2'b10;
    #1;
    chk("stall_gst_rsp_rdy", a_if.gst_rsp_rdy, 1'b0);
    chk("stall_host_rsp_vld", a_if.host_rsp_vld, 2'b01);
    tick();
    a_if.host_rsp_rdy = 2'b11;
    exp_a_rsp(0, 32'hCCCC, 1'b0);
    tick();
    a_if.gst_rsp_data = 32'hDDDD;
    a_if.gst_rsp_err  = 1'b1;
    exp_a_rsp(1, 32'hDDDD, 1'b1);
    tick();
    a_if.gst_rsp_data = 32'hEEEE;
    a_if.gst_rsp_err  = 1'b0;
    exp_a_rsp(0, 32'hEEEE, 1'b0);
    tick();
    a_if.gst_rsp_vld = 1'b0;
    #1;
    chk("drained_count", u_rr.u_id_fifo.count, 3'd0);
    chk("drained_orphan", a_if.orphan_rsp, 1'b0);

    // Accept host 1 alone so the rotating pointer favours host 0 next
    a_if.host_req_vld = 2'b10;
    exp_a(1, 32'h20);
    tick();
    a_if.host_req_vld = 2'b00;

    // Lock: host 1 stalls three cycles at 0x100 while host 0 joins in the second
    a_if.host_req_addr = {32'h100, 32'h10};
    a_if.host_req_vld  = 2'b10;
    a_if.gst_req_rdy   = 1'b0;
    #1;
    chk("lock_c1_addr", a_if.gst_req_addr, 32'h100);
    chk("lock_c1_vld", a_if.gst_req_vld, 1'b1);
    tick();
    a_if.host_req_vld = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lock_hold_addr", a_if.gst_req_addr, 32'h100);
      chk("lock_hold_rdy", a_if.host_req_rdy, 2'b00);
      tick();
    end
    a_if.gst_req_rdy = 1'b1;
    exp_a(1, 32'h100);
    #1;
    chk("lock_release_rdy", a_if.host_req_rdy, 2'b10);
    tick();
    a_if.host_req_vld = 2'b01;
    exp_a(0, 32'h10);
    tick();
    a_if.host_req_vld = 2'b00;
    #1;
    chk("pre_rst_count", u_rr.u_id_fifo.count, 3'd3);

    // Reset with IDs outstanding; the late guest response becomes an orphan
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_if.gst_rsp_vld  = 1'b1;
    a_if.gst_rsp_data = 32'h5555;
    #1;
    chk("orphan_gst_rsp_rdy", a_if.gst_rsp_rdy, 1'b1);
    chk("orphan_host_rsp_vld", a_if.host_rsp_vld, 2'b00);
    chk("orphan_not_yet", a_if.orphan_rsp, 1'b0);
    tick();
    a_if.gst_rsp_vld = 1'b0;
    #1;
    chk("orphan_set", a_if.orphan_rsp, 1'b1);
    tick();
    tick();
    chk("orphan_sticky", a_if.orphan_rsp, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("orphan_cleared", a_if.orphan_rsp, 1'b0);

    // Fixed priority, three hosts, depth 3 with responses flowing so pointers wrap
    b_if.host_req_vld = 3'b111;
    qb_req.push_back(0);
    qb_rsp.push_back(0);
    tick();
    b_if.gst_rsp_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_if.gst_rsp_data = 32'hD0 + i;
      qb_req.push_back(0);
      qb_rsp.push_back(0);
      tick();
    end
    b_if.host_req_vld = 3'b110;
    for (int i = 0; i < 2; i++) begin
      b_if.gst_rsp_data = 32'hE0 + i;
      qb_req.push_back(1);
      qb_rsp.push_back(1);
      tick();
    end
    b_if.host_req_vld = 3'b100;
    b_if.gst_rsp_data = 32'hF0;
    qb_req.push_back(2);
    qb_rsp.push_back(2);
    tick();
    b_if.host_req_vld = 3'b000;
    b_if.gst_rsp_data = 32'hF1;
    tick();
    b_if.gst_rsp_vld = 1'b0;
    #1;
    chk("b_count_end", u_fp.u_id_fifo.count, 2'd0);
    chk("b_orphan_end", b_if.orphan_rsp, 1'b0);

    tick();
    chk("a_req_left", qa_req.size(), 0);
    chk("a_rsp_left", qa_rsp.size(), 0);
    chk("b_req_left", qb_req.size(), 0);
    chk("b_rsp_left", qb_rsp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bti_arb_mux.md
# bti_arb_mux

Parametrised N-host to one-guest BTI arbiter/multiplexer with in-order response routing: the successor to the SoC address demux, needed so the instruction and data ports (plus future DMA) can share one guest such as a unified SRAM or flash. Requests are arbitrated round-robin or by fixed priority. A granted request is held until accepted. Each accepted request's host index is pushed into an outstanding-ID FIFO, which steers the in-order guest responses back to the issuing host.

## Interface
- BTI_AW, 32, request address width
- BTI_DW, 32, data width (multiple of 8)
- HOST_NUM, 2, number of host ports (≥2)
- OST_DEPTH, 4, max outstanding accepted-but-unanswered requests (≥1)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (host 0 highest)
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- host_req_vld  in  HOST_NUM  per-host request valid
- host_req_rdy  out  HOST_NUM  per-host request ready
- host_req_addr  in  HOST_NUM*BTI_AW  packed addresses, host k at [k*BTI_AW +: BTI_AW]
- host_req_cmd  in  HOST_NUM  1 = write, 0 = read
- host_req_wdata  in  HOST_NUM*BTI_DW  packed write data
- host_req_strb  in  HOST_NUM*BTI_DW/8  packed byte strobes
- host_rsp_vld  out  HOST_NUM  per-host response valid
- host_rsp_rdy  in  HOST_NUM  per-host response ready
- host_rsp_data  out  BTI_DW  response data, broadcast to all hosts (qualified by host_rsp_vld)
- host_rsp_err  out  1  response error, broadcast
- gst_req_vld / gst_req_rdy  out / in  1  guest request handshake
- gst_req_addr, gst_req_cmd, gst_req_wdata, gst_req_strb  out  BTI_AW, 1, BTI_DW, BTI_DW/8  muxed request fields
- gst_rsp_vld / gst_rsp_rdy  in / out  1  guest response handshake
- gst_rsp_data, gst_rsp_err  in  BTI_DW, 1  guest response payload
- orphan_rsp  out  1  sticky flag: guest response received with no outstanding ID

## Operation
- Grant: when the FIFO is not full and no lock is held, select among hosts with vld=1. RR selects starting at rr_ptr and wraps; fixed priority selects the lowest index.
- The granted host's fields are driven to gst_req_*. gst_req_vld=1 and host_req_rdy[g]=gst_req_rdy; all other host_req_rdy=0.
- Lock: if gst_req_vld=1 and gst_req_rdy=0, register lock=1 and lock_id=g. While locked, grant is forced to lock_id with no re-arbitration. Lock clears on acceptance.
- Accept (gst_req_vld & gst_req_rdy): push g into the ID FIFO. In RR mode, rr_ptr ← (g+1) mod HOST_NUM.
- FIFO full (count==OST_DEPTH): gst_req_vld=0 and all host_req_rdy=0. A pop in the same cycle does not unblock the push; the push waits until the next cycle.
- Response: if count>0, host_rsp_vld[head]=gst_rsp_vld and gst_rsp_rdy=host_rsp_rdy[head]. A response handshake pops the FIFO.
- Same-cycle push and pop: count unchanged, and both pointers advance.
- Empty FIFO with gst_rsp_vld=1: gst_rsp_rdy=1, the response is discarded, and orphan_rsp ← 1 (cleared only by rst).
- Writes also produce one guest response each and occupy an ID slot.

## Timing
- Request path and response path are combinational: zero added latency.
- The only registered state is rr_ptr, lock, lock_id, the FIFO storage and pointers, count, and orphan_rsp.
- Reset (rst=1 sampled at an edge) sets rr_ptr=0, lock=0, FIFO pointers=0, count=0, orphan_rsp=0.
- While rst=1, all vld/rdy outputs are forced to 0.
- Reset mid-transaction discards all outstanding IDs. Guest responses arriving after reset are orphans.
- Count width is $clog2(OST_DEPTH+1). FIFO pointers wrap at OST_DEPTH, including non-power-of-2 depths.

## Structure
- Shared package bti_pkg holds:
  - BTI_CMD_RD / BTI_CMD_WR constants
  - ARB_RR / ARB_FIXED mode constants
  - the packed-slice helper
- Sub-module bti_id_fifo: synchronous FIFO, parameters DW=$clog2(HOST_NUM) (min 1) and DEPTH=OST_DEPTH. It exposes push/pop/full/empty/count/head.
- Arbiter and muxing stay in bti_arb_mux.

## Test plan
- Two hosts both assert vld every cycle, gst_req_rdy=1, RR mode → grants alternate 0,1,0,1. After host 1 is accepted, rr_ptr=0.
- Host 1 requests addr 0x100 and gst_req_rdy is held 0 for 3 cycles, while host 0 asserts in cycle 2 → gst_req_addr stays 0x100 and grant stays 1 until acceptance; host 0 is granted next.
- OST_DEPTH=4 with the guest never responding → 4 requests accepted, then all host_req_rdy=0. One response popped → a new request is accepted the following cycle, not the same cycle.
- Host 0 read then host 1 read are accepted; the guest returns 0xAAAA then 0xBBBB → host 0 receives 0xAAAA and host 1 receives 0xBBBB. Holding host_rsp_rdy[0]=0 stalls gst_rsp_rdy.
- ARB_MODE=1 with three hosts all requesting → host 0 is granted every cycle until it deasserts, then host 1.
- rst pulsed with 2 outstanding, then the guest returns a response → gst_rsp_rdy=1, no host_rsp_vld is asserted, and orphan_rsp=1 until the next rst.
